// File: rtl/l1_tlb_refill.sv
// L1 TLB refill/replacement controller: owns tags and valid bits, issues PTW walks on a
// miss and writes the response into an invalid-first / tree-PLRU victim entry.
module l1_tlb_refill (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [26:0] io_req_bits_vpn,
  input  logic [6:0]  io_ptw_ptbr_asid,
  input  logic        tlb_miss,
  input  logic [7:0]  hits,
  output logic        io_ptw_req_valid,
  input  logic        io_ptw_req_ready,
  output logic [26:0] io_ptw_req_bits,
  input  logic        io_ptw_resp_valid,
  input  logic        io_ptw_resp_bits_error,
  input  logic [19:0] io_ptw_resp_bits_pte_ppn,
  input  logic [5:0]  io_ptw_resp_bits_pte_perm,
  input  logic        io_ptw_invalidate,
  output logic [33:0] tags_0,
  output logic [33:0] tags_1,
  output logic [33:0] tags_2,
  output logic [33:0] tags_3,
  output logic [33:0] tags_4,
  output logic [33:0] tags_5,
  output logic [33:0] tags_6,
  output logic [33:0] tags_7,
  output logic [7:0]  valid,
  output logic        refill_wen,
  output logic [2:0]  refill_idx,
  output logic [19:0] refill_ppn,
  output logic [5:0]  refill_perm
);

  typedef enum logic [1:0] {
    StReady          = 2'd0,
    StRequest        = 2'd1,
    StWait           = 2'd2,
    StWaitInvalidate = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [33:0] refill_tag_q, refill_tag_d;
  logic [2:0]  refill_idx_q, refill_idx_d;
  logic [33:0] tags_q [8];
  logic [7:0]  valid_q, valid_d;
  logic [6:0]  plru_q, plru_d;
  logic [2:0]  victim;
  logic [2:0]  plru_victim;
  logic [2:0]  hit_way;
  logic        wen;

  // Mark way w as most recently used along its path in the 3-level tree.
  function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] r;
    r = p;
    r[0] = ~w[2];
    r[3'd1 + {2'b00, w[2]}] = ~w[1];
    r[3'd3 + {1'b0, w[2], w[1]}] = ~w[0];
    return r;
  endfunction

  // Victim: lowest-index invalid entry, else follow the PLRU tree.
  always_comb begin
    logic v2, v1;
    v2 = plru_q[0];
    v1 = plru_q[3'd1 + {2'b00, v2}];
    plru_victim = {v2, v1, plru_q[3'd3 + {1'b0, v2, v1}]};
    victim = plru_victim;
    for (int i = 7; i >= 0; i--) begin
      if (!valid_q[i]) victim = 3'(i);
    end
  end

  // Lowest-index hit way, used for the PLRU touch on a hit.
  always_comb begin
    hit_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hits[i]) hit_way = 3'(i);
    end
  end

  // FSM next-state, refill capture and write strobe.
  always_comb begin
    state_d      = state_q;
    refill_tag_d = refill_tag_q;
    refill_idx_d = refill_idx_q;
    wen          = 1'b0;
    case (state_q)
      StReady: begin
        if (io_req_valid && tlb_miss) begin
          refill_tag_d = {io_ptw_ptbr_asid, io_req_bits_vpn};
          refill_idx_d = victim;
          state_d      = StRequest;
        end
      end
      StRequest: begin
        if (io_ptw_invalidate) state_d = StReady;
        else if (io_ptw_req_ready) state_d = StWait;
      end
      StWait: begin
        if (io_ptw_resp_valid) begin
          // A response racing an sfence is dropped.
          wen     = ~io_ptw_invalidate;
          state_d = StReady;
        end else if (io_ptw_invalidate) begin
          state_d = StWaitInvalidate;
        end
      end
      StWaitInvalidate: begin
        if (io_ptw_resp_valid) state_d = StReady;
      end
      default: state_d = StReady;
    endcase
  end

  // Valid and PLRU next state; invalidate overrides any write.
  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (wen) begin
      valid_d[refill_idx_q] = ~io_ptw_resp_bits_error;
      plru_d                = plru_touch(plru_q, refill_idx_q);
    end else if (io_req_valid && io_req_ready && (|hits)) begin
      plru_d = plru_touch(plru_q, hit_way);
    end
    if (io_ptw_invalidate) valid_d = '0;
  end

  // Control and replacement state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StReady;
      refill_tag_q <= '0;
      refill_idx_q <= '0;
      valid_q      <= '0;
      plru_q       <= '0;
    end else begin
      state_q      <= state_d;
      refill_tag_q <= refill_tag_d;
      refill_idx_q <= refill_idx_d;
      valid_q      <= valid_d;
      plru_q       <= plru_d;
    end
  end

  // Tag array, written only by a refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) tags_q[i] <= '0;
    end else if (wen) begin
      tags_q[refill_idx_q] <= refill_tag_q;
    end
  end

  assign io_req_ready     = (state_q == StReady);
  assign io_ptw_req_valid = (state_q == StRequest);
  assign io_ptw_req_bits  = refill_tag_q[26:0];
  assign refill_wen       = wen;
  assign refill_idx       = refill_idx_q;
  assign refill_ppn       = wen ? io_ptw_resp_bits_pte_ppn : 20'd0;
  assign refill_perm      = (wen && !io_ptw_resp_bits_error) ? io_ptw_resp_bits_pte_perm : 6'd0;
  assign valid            = valid_q;
  assign tags_0           = tags_q[0];
  assign tags_1           = tags_q[1];
  assign tags_2           = tags_q[2];
  assign tags_3           = tags_q[3];
  assign tags_4           = tags_q[4];
  assign tags_5           = tags_q[5];
  assign tags_6           = tags_q[6];
  assign tags_7           = tags_q[7];

endmodule
